// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues pc to a synchronous instruction memory, buffers
// returned words in a 2-entry FIFO and hands them to decode over valid/ready.
module fetch_stage #(
    parameter int unsigned PC_WIDTH    = 6,
    parameter int unsigned INSTR_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   PCincr,
    input  logic                   branch_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    entry_t                fifo_q [FIFO_DEPTH];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  inflight_q;
    logic [PC_WIDTH-1:0]   inflight_pc_q;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [CNT_W-1:0]      occupancy;

    // Handshake and issue decisions; a slot is free if the FIFO plus the
    // outstanding read leaves room, or if decode drains an entry this cycle.
    always_comb begin
        imem_addr   = pc;
        instr_valid = (count_q != '0) & ~branch_en & ~reset;
        pop         = instr_valid & instr_ready;
        occupancy   = count_q + CNT_W'(inflight_q);
        issue       = ~reset & ~branch_en & ((occupancy < CNT_W'(FIFO_DEPTH)) | pop);
        PCincr      = issue;
        push        = inflight_q & ~branch_en & ~reset;
        instr       = fifo_q[rd_ptr_q].instr;
        instr_pc    = fifo_q[rd_ptr_q].pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (branch_en) begin
            // Wrong-path flush: buffered entries and the returning word are dropped
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: imem_rdata};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: PC stage and ROM models, directed timing
// checks, random traffic, and a scoreboard of the architectural instruction stream.
module tb_fetch_stage;

    localparam int unsigned PW = 6;
    localparam int unsigned IW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] pc;
    logic          PCincr;
    logic          branch_en;
    logic [PW-1:0] branch_target;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] instr;
    logic [PW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;

    fetch_stage #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .PCincr      (PCincr),
        .branch_en   (branch_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom(input logic [PW-1:0] a);
        return 24'hA00000 + IW'(a);
    endfunction

    // PC stage and synchronous instruction memory
    always_ff @(posedge clk) begin
        if (reset)          pc <= '0;
        else if (branch_en) pc <= branch_target;
        else if (PCincr)    pc <= pc + PW'(1);
    end

    always_ff @(posedge clk) imem_rdata <= rom(imem_addr);

    // Architectural stream: after a redirect to T, decode sees T, T+1, ... in order
    typedef struct packed {
        logic [PW-1:0] pc;
        logic [IW-1:0] ins;
    } exp_t;

    exp_t          exp_q[$];
    logic [PW-1:0] next_pc;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: next_pc, ins: rom(next_pc)});
            next_pc = next_pc + PW'(1);
        end
    endtask

    task automatic redirect(input logic [PW-1:0] t);
        exp_q.delete();
        next_pc = t;
        refill();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks handshake rules
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_pc;
    logic [IW-1:0] prev_ins;
    exp_t          e;

    always @(negedge clk) begin
        if (prev_stall && !reset && !branch_en) begin
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_pc", 32'(instr_pc), 32'(prev_pc));
            check("hold_instr", 32'(instr), 32'(prev_ins));
        end
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", 32'(instr_pc), 32'(e.pc));
                check("sb_instr", 32'(instr), 32'(e.ins));
                refill();
            end
            check("pop_pcincr", 32'(PCincr), 32'd1);
        end
        if (reset || branch_en) begin
            check("flush_pcincr", 32'(PCincr), 32'd0);
            check("flush_valid", 32'(instr_valid), 32'd0);
        end
        if (dut.count_q > 2) check("occupancy", 32'(dut.count_q), 32'd2);
        prev_stall = instr_valid & ~instr_ready;
        prev_pc    = instr_pc;
        prev_ins   = instr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_pc(input logic [PW-1:0] p, input string nm);
        int k = 0;
        do begin
            tick();
            smp();
            k++;
        end while (!(instr_valid && instr_pc == p) && k < 100);
        if (!(instr_valid && instr_pc == p)) check(nm, 32'(instr_pc), 32'(p));
    endtask

    initial begin
        reset = 1'b1; branch_en = 1'b0; branch_target = '0; instr_ready = 1'b0;
        redirect('0);

        // Reset values
        tick(); smp();
        check("rst_pcincr", 32'(PCincr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);

        // Cycle R and fetch latency
        tick(); reset = 1'b0; instr_ready = 1'b1; smp();
        check("R_pcincr", 32'(PCincr), 32'd1);
        check("R_addr", 32'(imem_addr), 32'd0);
        tick(); smp();
        check("R1_valid", 32'(instr_valid), 32'd0);
        check("R1_addr", 32'(imem_addr), 32'd1);
        tick(); smp();
        check("R2_valid", 32'(instr_valid), 32'd1);
        check("R2_pc", 32'(instr_pc), 32'd0);
        check("R2_instr", 32'(instr), 32'hA00000);

        // Stall from pc 4 for 5 cycles
        wait_pc(PW'(3), "wait_pc3");
        tick(); instr_ready = 1'b0; smp();
        check("stall_head", 32'(instr_pc), 32'd4);
        for (int k = 1; k < 5; k++) begin
            tick(); smp();
            if (k >= 2) check("stall_pcincr", 32'(PCincr), 32'd0);
        end
        check("stall_full", 32'(dut.count_q), 32'd2);
        tick(); instr_ready = 1'b1; smp();
        check("release_pcincr", 32'(PCincr), 32'd1);

        // Branch during free run
        tick(); tick(); tick();
        tick(); branch_en = 1'b1; branch_target = PW'(6'h20); redirect(PW'(6'h20)); smp();
        check("br_b_valid", 32'(instr_valid), 32'd0);
        tick(); branch_en = 1'b0; smp();
        check("br_b1_valid", 32'(instr_valid), 32'd0);
        tick(); smp();
        check("br_b2_valid", 32'(instr_valid), 32'd0);
        tick(); smp();
        check("br_b3_valid", 32'(instr_valid), 32'd1);
        check("br_b3_pc", 32'(instr_pc), 32'h20);
        check("br_b3_instr", 32'(instr), 32'hA00020);

        // Branch while full and stalled
        tick(); instr_ready = 1'b0;
        tick(); tick(); tick(); smp();
        check("brfull_count", 32'(dut.count_q), 32'd2);
        tick(); branch_en = 1'b1; branch_target = PW'(6'h10); redirect(PW'(6'h10));
        tick(); branch_en = 1'b0; instr_ready = 1'b1;
        tick(); tick(); smp();
        check("brfull_valid", 32'(instr_valid), 32'd1);
        check("brfull_pc", 32'(instr_pc), 32'h10);

        // One-cycle reset pulse with two entries buffered
        tick(); instr_ready = 1'b0;
        tick(); tick(); smp();
        check("rstpulse_count", 32'(dut.count_q), 32'd2);
        tick(); reset = 1'b1; redirect('0); smp();
        check("rstpulse_valid", 32'(instr_valid), 32'd0);
        tick(); reset = 1'b0; instr_ready = 1'b1; smp();
        check("rstpulse_R_valid", 32'(instr_valid), 32'd0);
        tick(); smp();
        check("rstpulse_R1_valid", 32'(instr_valid), 32'd0);
        tick(); smp();
        check("rstpulse_R2_valid", 32'(instr_valid), 32'd1);
        check("rstpulse_R2_pc", 32'(instr_pc), 32'd0);

        // PC wrap 63 -> 0
        tick(); branch_en = 1'b1; branch_target = PW'(6'h3C); redirect(PW'(6'h3C));
        tick(); branch_en = 1'b0;
        wait_pc(PW'(63), "wait_pc63");
        check("wrap_63_instr", 32'(instr), 32'hA0003F);
        tick(); smp();
        check("wrap_valid", 32'(instr_valid), 32'd1);
        check("wrap_pc", 32'(instr_pc), 32'd0);
        check("wrap_instr", 32'(instr), 32'hA00000);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            tick();
            reset         = ($urandom_range(99) < 2);
            branch_en     = ($urandom_range(99) < 6);
            branch_target = PW'($urandom());
            instr_ready   = ($urandom_range(99) < 70);
            if (reset)          redirect('0);
            else if (branch_en) redirect(branch_target);
        end
        tick(); reset = 1'b0; branch_en = 1'b0; instr_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        smp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
